// File: rtl/alu_mul_sequencer_if.sv
// Purpose: bundle of the multiply request, CPU ALU request, shared ALU
//          connection and result/status signals of alu_mul_sequencer.
// Modports:
//   slave  - sequencer view: takes start/operands, CPU ALU requests and
//            ALU results; drives the ALU mux, busy/done and the product.
//   master - environment view (CPU + ALU), the mirror image of slave.
interface alu_mul_sequencer_if;
  logic        start;
  logic        signed_mode;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [15:0] cpu_alu_a;
  logic [15:0] cpu_alu_b;
  logic [4:0]  cpu_alu_op;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [4:0]  alu_op;
  logic [15:0] alu_q;
  logic        alu_carry;
  logic        busy;
  logic        done;
  logic [15:0] result_hi;
  logic [15:0] result_lo;

  modport slave (
    input  start, signed_mode, op_a, op_b,
    input  cpu_alu_a, cpu_alu_b, cpu_alu_op,
    input  alu_q, alu_carry,
    output alu_a, alu_b, alu_op,
    output busy, done, result_hi, result_lo
  );

  modport master (
    output start, signed_mode, op_a, op_b,
    output cpu_alu_a, cpu_alu_b, cpu_alu_op,
    output alu_q, alu_carry,
    input  alu_a, alu_b, alu_op,
    input  busy, done, result_hi, result_lo
  );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Purpose: 16x16 -> 32 shift-and-add multiplier that borrows the CPU's
//          shared 16-bit ALU (add + carry-out) once per iteration and
//          passes the CPU's ALU requests through whenever it is not running.
// Ports:
//   i_clk - system clock, rising edge
//   i_rst - synchronous active-high reset, aborts any operation
//   bus   - alu_mul_sequencer_if.slave: start/signed_mode/op_a/op_b,
//           cpu_alu_* requests, alu_* mux outputs, alu_q/alu_carry,
//           busy, done, result_hi/result_lo
//
// state  | meaning
// IDLE   | ALU passthrough, waiting for start
// RUN    | owns the ALU, one shift-add iteration per cycle (ITER cycles)
// FIX    | applies sign to the magnitude product, latches result
// DONE   | one-cycle done pulse, start ignored
module alu_mul_sequencer #(
  parameter logic [4:0] OP_ADD = 5'b00001,
  parameter int         ITER   = 16
) (
  input logic               i_clk,
  input logic               i_rst,
  alu_mul_sequencer_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  localparam logic [3:0] LAST_ITER = 4'(ITER - 1);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_p_hi;
  logic [15:0] r_p_lo;
  logic [15:0] r_mcand;
  logic        r_neg;
  logic [3:0]  r_count;
  logic [15:0] r_result_hi;
  logic [15:0] r_result_lo;

  logic        w_own;
  logic        w_busy;
  logic        w_done;
  logic [15:0] w_sum;
  logic        w_c;
  logic [31:0] w_prod;
  logic [31:0] w_fixed;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_own  = 1'b0;
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_IDLE: if (bus.start) w_next = S_RUN;
      S_RUN: begin
        w_own  = 1'b1;
        w_busy = 1'b1;
        if (r_count == LAST_ITER) w_next = S_FIX;
      end
      S_FIX: begin
        w_busy = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // The ALU always computes P_hi + mcand during RUN; the multiplier LSB
  // decides whether that sum (and its carry) or plain P_hi is shifted in.
  assign w_sum   = r_p_lo[0] ? bus.alu_q : r_p_hi;
  assign w_c     = r_p_lo[0] & bus.alu_carry;
  assign w_prod  = {r_p_hi, r_p_lo};
  assign w_fixed = r_neg ? (~w_prod + 32'd1) : w_prod;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_p_hi      <= '0;
      r_p_lo      <= '0;
      r_mcand     <= '0;
      r_neg       <= 1'b0;
      r_count     <= '0;
      r_result_hi <= '0;
      r_result_lo <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.start) begin
          // Magnitudes only; 0x8000 negates to itself, which is the correct
          // unsigned magnitude.
          r_mcand <= (bus.signed_mode & bus.op_a[15]) ? 16'(-bus.op_a) : bus.op_a;
          r_p_lo  <= (bus.signed_mode & bus.op_b[15]) ? 16'(-bus.op_b) : bus.op_b;
          r_p_hi  <= '0;
          r_neg   <= bus.signed_mode & (bus.op_a[15] ^ bus.op_b[15]);
          r_count <= '0;
        end
        S_RUN: begin
          r_p_hi  <= {w_c, w_sum[15:1]};
          r_p_lo  <= {w_sum[0], r_p_lo[15:1]};
          r_count <= r_count + 4'd1;
        end
        S_FIX: {r_result_hi, r_result_lo} <= w_fixed;
        default: ;
      endcase
    end
  end

  assign bus.alu_a     = w_own ? r_p_hi  : bus.cpu_alu_a;
  assign bus.alu_b     = w_own ? r_mcand : bus.cpu_alu_b;
  assign bus.alu_op    = w_own ? OP_ADD  : bus.cpu_alu_op;
  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.result_hi = r_result_hi;
  assign bus.result_lo = r_result_lo;
endmodule

// File: tb/tb_alu_mul_sequencer.sv
module tb_alu_mul_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   done_cnt = 0;
  logic [31:0] sb_q[$];

  alu_mul_sequencer_if bus();

  alu_mul_sequencer dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Shared ALU model: add with carry-out for op 00001, XOR otherwise.
  assign {bus.alu_carry, bus.alu_q} = (bus.alu_op == 5'b00001)
      ? ({1'b0, bus.alu_a} + {1'b0, bus.alu_b})
      : {1'b0, bus.alu_a ^ bus.alu_b};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every done pulse pops one expected product.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      done_cnt++;
      check("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) check("result", {bus.result_hi, bus.result_lo}, sb_q.pop_front());
    end
  end

  task automatic run_op(input bit sm, input logic [15:0] a, input logic [15:0] b,
                        input int inj, input bit start_in_done, input int rst_at);
    logic [15:0] mc, ph, pl;
    logic [16:0] s;
    logic [31:0] ea, eb, exp;
    int busy_n, lat, d0;
    bit seen, stop;
    busy_n = 0; lat = 0; seen = 0; stop = 0;
    mc = (sm & a[15]) ? 16'(-a) : a;
    pl = (sm & b[15]) ? 16'(-b) : b;
    ph = 16'h0;
    ea = sm ? {{16{a[15]}}, a} : {16'h0, a};
    eb = sm ? {{16{b[15]}}, b} : {16'h0, b};
    exp = ea * eb;
    d0 = done_cnt;
    @(negedge clk);
    bus.start = 1'b1; bus.signed_mode = sm; bus.op_a = a; bus.op_b = b;
    sb_q.push_back(exp);
    @(posedge clk);
    for (int i = 1; i <= 40 && !seen && !stop; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (i == inj) begin
        bus.start = 1'b1; bus.op_a = ~a; bus.op_b = b + 16'd1; bus.signed_mode = ~sm;
      end
      if (i <= 16) begin
        check("run_alu_a", bus.alu_a, ph);
        check("run_alu_b", bus.alu_b, mc);
        check("run_alu_op", bus.alu_op, 5'b00001);
        s = pl[0] ? ({1'b0, ph} + {1'b0, mc}) : {1'b0, ph};
        ph = {s[16], s[15:1]};
        pl = {s[0], pl[15:1]};
      end
      if (bus.busy) busy_n++;
      if (bus.done) begin
        seen = 1'b1; lat = i;
        if (start_in_done) bus.start = 1'b1;
      end
      if (i == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_result", {bus.result_hi, bus.result_lo}, 32'h0);
        check("rst_passthru_a", bus.alu_a, bus.cpu_alu_a);
        check("rst_passthru_op", bus.alu_op, bus.cpu_alu_op);
        sb_q.delete();
        stop = 1'b1;
      end
    end
    if (stop) begin
      repeat (25) @(negedge clk);
      check("rst_no_done", done_cnt, d0);
      check("rst_idle_busy", bus.busy, 1'b0);
      return;
    end
    check("done_seen", seen, 1'b1);
    check("latency", lat, 18);
    check("busy_cycles", busy_n, 17);
    repeat (3) begin
      @(negedge clk);
      bus.start = 1'b0;
      check("idle_after_done", bus.busy, 1'b0);
    end
    check("single_done", done_cnt, d0 + 1);
    check("result_held", {bus.result_hi, bus.result_lo}, exp);
  endtask

  initial begin
    bus.start = 1'b0; bus.signed_mode = 1'b0; bus.op_a = '0; bus.op_b = '0;
    bus.cpu_alu_a = '0; bus.cpu_alu_b = '0; bus.cpu_alu_op = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", bus.busy, 1'b0);
    check("reset_done", bus.done, 1'b0);
    check("reset_result", {bus.result_hi, bus.result_lo}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", bus.busy, 1'b0);

    bus.cpu_alu_a = 16'h1234; bus.cpu_alu_b = 16'h00FF; bus.cpu_alu_op = 5'b10000;
    #1;
    check("pass_a", bus.alu_a, 16'h1234);
    check("pass_b", bus.alu_b, 16'h00FF);
    check("pass_op", bus.alu_op, 5'b10000);
    check("pass_q", bus.alu_q, 16'h12CB);

    // CPU keeps requesting a different op while the multiplier runs.
    bus.cpu_alu_a = 16'hAAAA; bus.cpu_alu_b = 16'h5555; bus.cpu_alu_op = 5'b10000;

    run_op(1'b0, 16'h0003, 16'h0005, 0, 1'b0, 0);
    run_op(1'b0, 16'hFFFF, 16'hFFFF, 0, 1'b0, 0);
    run_op(1'b1, 16'hFFFD, 16'h0005, 0, 1'b0, 0);
    run_op(1'b1, 16'h8000, 16'h8000, 0, 1'b0, 0);
    run_op(1'b1, 16'h8000, 16'h0001, 0, 1'b0, 0);
    run_op(1'b1, 16'h0000, 16'h8000, 0, 1'b0, 0);
    run_op(1'b1, 16'h7FFF, 16'h8001, 0, 1'b0, 0);
    run_op(1'b0, 16'h1234, 16'h0056, 5, 1'b1, 0);
    run_op(1'b0, 16'h0100, 16'h0033, 0, 1'b0, 8);
    run_op(1'b0, 16'h0007, 16'h0006, 0, 1'b0, 0);

    check("sb_drained", sb_q.size(), 0);
    check("final_result", {bus.result_hi, bus.result_lo}, 32'h0000_002A);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
Multi-cycle 16x16 -> 32-bit multiply controller that borrows the CPU's shared 16-bit combinational ALU. It runs a shift-and-add loop, using the ALU add operation and its carry-out once per iteration. While idle it passes the CPU's ALU operand/op requests straight through. While running it owns the ALU and stalls the CPU. Signed mode is handled by magnitude conversion at load and a sign fix-up at the end.

Parameters:
OP_ADD, 5'b00001, ALU op code for A+B; the ALU overflow output equals carry-out for this op.
ITER, 16, shift-add iterations; equals the ALU width and is not intended to change.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request multiply; sampled only in IDLE
signed_mode  input  1  1 = two's-complement operands/result, 0 = unsigned; sampled with start
op_a  input  16  multiplicand; sampled with start
op_b  input  16  multiplier; sampled with start
cpu_alu_a  input  16  CPU's ALU A operand request
cpu_alu_b  input  16  CPU's ALU B operand request
cpu_alu_op  input  5  CPU's ALU op request
alu_a  output  16  to ALU A (combinational mux)
alu_b  output  16  to ALU B (combinational mux)
alu_op  output  5  to ALU op (combinational mux)
alu_q  input  16  ALU result
alu_carry  input  1  ALU overflow output (carry-out when alu_op=OP_ADD)
busy  output  1  high in RUN and FIX; CPU stall
done  output  1  one-cycle pulse in DONE
result_hi  output  16  product bits 31:16, held until next accepted start
result_lo  output  16  product bits 15:0, held until next accepted start

Behaviour:
- Reset (synchronous): state=IDLE; busy=0; done=0; result_hi=result_lo=0; count=0; internal P_hi, P_lo, mcand and neg registers = 0. Reset in any state, including mid-RUN, aborts the operation. No done pulse is produced and the ALU returns to passthrough the next cycle.
- States: IDLE, RUN, FIX, DONE.
- IDLE: alu_a/alu_b/alu_op = cpu_alu_* (pure combinational passthrough).
  - On start=1: mcand = signed_mode & op_a[15] ? -op_a : op_a.
  - P_lo = signed_mode & op_b[15] ? -op_b : op_b.
  - P_hi = 0; neg = signed_mode & (op_a[15]^op_b[15]); count = 0; go to RUN.
- RUN (exactly ITER cycles, count 0..15):
  - alu_a = P_hi; alu_b = mcand; alu_op = OP_ADD; the cpu_alu_* inputs are ignored.
  - If P_lo[0]=1: sum = alu_q, c = alu_carry. Otherwise sum = P_hi, c = 0.
  - Update: P_hi <= {c, sum[15:1]}; P_lo <= {sum[0], P_lo[15:1]}; count <= count+1.
  - After the count=15 iteration, go to FIX.
- FIX (1 cycle, always entered so latency is uniform):
  - {result_hi, result_lo} <= neg ? -{P_hi, P_lo} (32-bit two's complement) : {P_hi, P_lo}.
  - ALU is in passthrough; go to DONE.
- DONE (1 cycle): done=1, busy=0, ALU in passthrough; go to IDLE. A start in DONE is ignored.
- Latency: start accepted at edge k, RUN spans cycles k+1..k+16, FIX at k+17, done high during cycle k+18. busy is high in cycles k+1..k+17.
- start while busy or in DONE: ignored, with no queuing. Operand changes after acceptance have no effect.
- Signed edge cases:
  - -0x8000 magnitude = 0x8000, handled correctly as unsigned 16-bit.
  - 0x8000*0x8000 signed = 0x4000_0000.
  - Zero operands give zero, even when neg=1, since -0 = 0.
- result_* change only in FIX and on reset.

Test Plan:
- Unsigned: start, op_a=0x0003, op_b=0x0005, signed_mode=0 -> done in cycle k+18, result=0x0000_000F; busy high exactly 17 cycles.
- Carry path: unsigned 0xFFFF*0xFFFF -> result_hi=0xFFFE, result_lo=0x0001; during RUN, alu_op=5'b00001 and alu_a tracks P_hi.
- Signed: 0xFFFD (-3) * 0x0005 -> 0xFFFF_FFF1. 0x8000*0x8000 -> 0x4000_0000. 0x8000*0x0001 -> 0xFFFF_8000.
- Passthrough/ownership: in IDLE, drive cpu_alu_a=0x1234, cpu_alu_b=0x00FF, cpu_alu_op=5'b10000 -> alu_* equal these same-cycle. During RUN, alu_* ignore cpu_alu_*.
- Start while busy: second start at k+5 with different operands -> ignored, first result returned, single done pulse. Start during DONE also ignored.
- Reset mid-run: rst=1 at k+8 -> next cycle state IDLE, busy=0, results=0, no done pulse; a following fresh 7*6 start returns 0x0000_002A.
